axi_mem_port_arbiter: RTL and testbench
=======================================

// Module: axi_mem_port_arbiter
// PURPOSE
//  Shares the single-port AXI backing memory (mem_en/mem_we/mem_addr/mem_wdata/mem_rdata)
//  between the write-burst engine and the read-burst engine. Grants whole INCR bursts
//  round-robin, sequences one memory access per cycle and absorbs the 1-cycle read latency.
//  Read return data passes through a 2-entry buffer that honours downstream backpressure.
// PARAMETERS
//  DATA_WIDTH  32    data beat width
//  ADDR_WIDTH  10    word address width; addresses wrap modulo 2**ADDR_WIDTH
//  LEN_WIDTH   8     burst length field; beats = len+1 (AXI encoding)
// PORTS
//  ACLK           in   1           clock
//  ARESETn        in   1           synchronous, active-low reset
//  wr_req         in   1           write burst request; wr_addr/wr_len valid while high
//  wr_addr        in   ADDR_WIDTH  write start word address
//  wr_len         in   LEN_WIDTH   write beats-1
//  wr_gnt         out  1           accept pulse; burst captured when wr_req && wr_gnt
//  wr_data_valid  in   1           write beat valid
//  wr_data        in   DATA_WIDTH  write beat
//  wr_data_ready  out  1           high for the whole write burst
//  wr_done        out  1           1-cycle pulse after last write beat stored
//  rd_req, rd_addr, rd_len, rd_gnt  as write side, for read bursts
//  rd_data_valid  out  1           read beat available (buffer not empty)
//  rd_data        out  DATA_WIDTH  read beat, buffer head
//  rd_data_ready  in   1           consumer accepts beat on valid && ready
//  rd_done        out  1           1-cycle pulse after last read beat popped
//  mem_en, mem_we out  1           memory strobe / write enable
//  mem_addr       out  ADDR_WIDTH  memory word address
//  mem_wdata      out  DATA_WIDTH  memory write data
//  mem_rdata      in   DATA_WIDTH  registered memory read data, valid 1 cycle after read strobe
// BEHAVIOUR
//  - Reset: state IDLE, beat counters/buffer/inflight flag cleared, last_served=READ;
//    all outputs 0 (gnt gated with ARESETn). Reset mid-burst aborts silently: no done pulse,
//    buffered data discarded, memory contents untouched.
//  - FSM IDLE -> WR_BURST | RD_BURST -> IDLE. gnt combinational only in IDLE.
//  - Arbitration in IDLE: one req -> grant it; both -> grant side != last_served (write
//    first after reset); last_served updated on grant. Only one gnt high per cycle.
//  - Grant cycle latches addr and len; burst starts next cycle. Requester may drop req after.
//  - WR_BURST: wr_data_ready=1; each wr_data_valid beat drives mem_en=1, mem_we=1,
//    mem_addr=cur, mem_wdata=wr_data same cycle; cur+=1 (wraps 2**ADDR_WIDTH-1 -> 0).
//    After beat len+1: wr_done pulses next cycle, state IDLE. Throughput 1 beat/cycle.
//  - RD_BURST: issue read (mem_en=1, mem_we=0) when beats remain and
//    buf_count - pop + inflight < 2; returning mem_rdata pushed into 2-entry FIFO next cycle.
//    Sustains 1 beat/cycle with rd_data_ready held high; never overflows buffer.
//    Exit when all beats issued, inflight=0, buffer empty: rd_done pulses, state IDLE.
//  - Requests arriving mid-burst wait; arbitration resumes the cycle state returns to IDLE.
//  - mem_* outputs 0 whenever no access is issued. No read/write overlap possible.
// CONFIGURATION
//  MEM_ARB_STATS_EN defined: adds outputs wr_beat_cnt, rd_beat_cnt (32b each),
//  incremented per memory write / read-beat pop, saturating at all-ones, cleared by reset.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 wr_req addr=0x010 len=3 data A0..A3 -> mem 0x010..0x013 = A0..A3, wr_done 1 cycle after A3
//  2 rd_req addr=0x010 len=3, ready=1 -> A0..A3 on consecutive cycles, rd_done after A3 pop
//  3 wr_req and rd_req same cycle after reset -> wr_gnt first; rd_gnt in first IDLE after wr_done
//  4 write addr=0x3FE len=3 -> mem 0x3FE,0x3FF,0x000,0x001 written (wrap)
//  5 read len=7 with rd_data_ready toggled 1,0,0,1,... -> 8 beats in order, none lost/duplicated,
//    never more than 2 reads buffered+inflight
//  6 ARESETn=0 during beat 2 of len=7 read -> outputs 0, no rd_done; next request serviced normally

Source files
------------

// File: rtl/axi_mem_port_arbiter_if.sv
// Bus bundle between the write/read burst engines, the arbiter and the single-port memory.
// The slave modport is the arbiter's view; master is the engines-plus-memory view.
interface axi_mem_port_arbiter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int LEN_WIDTH  = 8
);
   logic                  wr_req;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [LEN_WIDTH-1:0]  wr_len;
   logic                  wr_gnt;
   logic                  wr_data_valid;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  wr_data_ready;
   logic                  wr_done;

   logic                  rd_req;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [LEN_WIDTH-1:0]  rd_len;
   logic                  rd_gnt;
   logic                  rd_data_valid;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_data_ready;
   logic                  rd_done;

   logic                  mem_en;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;

   modport slave (
      input  wr_req, wr_addr, wr_len, wr_data_valid, wr_data,
      output wr_gnt, wr_data_ready, wr_done,
      input  rd_req, rd_addr, rd_len, rd_data_ready,
      output rd_gnt, rd_data_valid, rd_data, rd_done,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output wr_req, wr_addr, wr_len, wr_data_valid, wr_data,
      input  wr_gnt, wr_data_ready, wr_done,
      output rd_req, rd_addr, rd_len, rd_data_ready,
      input  rd_gnt, rd_data_valid, rd_data, rd_done,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/axi_mem_port_arbiter.sv
// Round-robin burst arbiter sharing one single-port memory between write and read engines.
// Define MEM_ARB_STATS_EN to add saturating write/read beat counters.
module axi_mem_port_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int LEN_WIDTH  = 8
) (
   input  logic ACLK,
   input  logic ARESETn,
   axi_mem_port_arbiter_if.slave bus
`ifdef MEM_ARB_STATS_EN
   ,
   output logic [31:0] wr_beat_cnt,
   output logic [31:0] rd_beat_cnt
`endif
);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] WR_BURST = 2'd1;
   localparam logic [1:0] RD_BURST = 2'd2;

   logic [1:0]            state;
   logic                  last_rd;
   logic [ADDR_WIDTH-1:0] cur;
   logic [LEN_WIDTH:0]    beats_left;
   logic [DATA_WIDTH-1:0] buf_mem [2];
   logic                  wptr, rptr;
   logic [1:0]            buf_count;
   logic                  inflight;
   logic                  wr_done_q, rd_done_q;

   logic                  gnt_w, gnt_r, wr_beat, rd_issue, pop, last_pop;
   logic [2:0]            occ;

   always_comb begin
      gnt_w    = ARESETn && (state == IDLE) && bus.wr_req && (!bus.rd_req || last_rd);
      gnt_r    = ARESETn && (state == IDLE) && bus.rd_req && !gnt_w;
      wr_beat  = ARESETn && (state == WR_BURST) && bus.wr_data_valid;
      pop      = ARESETn && (buf_count != 2'd0) && bus.rd_data_ready;
      // Slots committed next cycle: what stays buffered plus the read already in flight.
      occ      = {1'b0, buf_count} + {2'b0, inflight} - {2'b0, pop};
      rd_issue = ARESETn && (state == RD_BURST) && (beats_left != '0) && (occ < 3'd2);
      last_pop = pop && (buf_count == 2'd1) && !inflight && (beats_left == '0);
   end

   assign bus.wr_gnt        = gnt_w;
   assign bus.rd_gnt        = gnt_r;
   assign bus.wr_data_ready = ARESETn && (state == WR_BURST);
   assign bus.wr_done       = ARESETn && wr_done_q;
   assign bus.rd_done       = ARESETn && rd_done_q;
   assign bus.rd_data_valid = ARESETn && (buf_count != 2'd0);
   assign bus.rd_data       = bus.rd_data_valid ? buf_mem[rptr] : '0;
   assign bus.mem_en        = wr_beat || rd_issue;
   assign bus.mem_we        = wr_beat;
   assign bus.mem_addr      = (wr_beat || rd_issue) ? cur : '0;
   assign bus.mem_wdata     = wr_beat ? bus.wr_data : '0;

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         state      <= IDLE;
         last_rd    <= 1'b1;
         cur        <= '0;
         beats_left <= '0;
         buf_mem[0] <= '0;
         buf_mem[1] <= '0;
         wptr       <= 1'b0;
         rptr       <= 1'b0;
         buf_count  <= 2'd0;
         inflight   <= 1'b0;
         wr_done_q  <= 1'b0;
         rd_done_q  <= 1'b0;
      end else begin
         wr_done_q <= 1'b0;
         rd_done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (gnt_w || gnt_r) begin
                  cur        <= gnt_w ? bus.wr_addr : bus.rd_addr;
                  beats_left <= {1'b0, (gnt_w ? bus.wr_len : bus.rd_len)} + 1'b1;
                  last_rd    <= gnt_r;
                  state      <= gnt_w ? WR_BURST : RD_BURST;
               end
            end
            WR_BURST: begin
               if (wr_beat) begin
                  cur        <= cur + 1'b1;
                  beats_left <= beats_left - 1'b1;
                  if (beats_left == {{LEN_WIDTH{1'b0}}, 1'b1}) begin
                     state     <= IDLE;
                     wr_done_q <= 1'b1;
                  end
               end
            end
            RD_BURST: begin
               // beats_left counts reads still to issue; exit is keyed to the final pop.
               if (rd_issue) begin
                  cur        <= cur + 1'b1;
                  beats_left <= beats_left - 1'b1;
               end
               if (last_pop) begin
                  state     <= IDLE;
                  rd_done_q <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase

         inflight <= rd_issue;
         if (inflight) begin
            buf_mem[wptr] <= bus.mem_rdata;
            wptr          <= ~wptr;
         end
         if (pop) rptr <= ~rptr;
         buf_count <= buf_count + {1'b0, inflight} - {1'b0, pop};
      end
   end

`ifdef MEM_ARB_STATS_EN
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         wr_beat_cnt <= '0;
         rd_beat_cnt <= '0;
      end else begin
         if (wr_beat && (wr_beat_cnt != '1)) wr_beat_cnt <= wr_beat_cnt + 1'b1;
         if (pop && (rd_beat_cnt != '1))     rd_beat_cnt <= rd_beat_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_axi_mem_port_arbiter.sv
// Directed self-checking bench for axi_mem_port_arbiter with a registered single-port memory.
module tb_axi_mem_port_arbiter;

   logic ACLK;
   logic ARESETn;
   int   checks = 0;
   int   errors = 0;

   localparam logic [31:0] A_BASE = 32'hA000_00A0;
   localparam logic [31:0] B_BASE = 32'hB000_00B0;
   localparam logic [31:0] C_BASE = 32'hC000_00C0;
   localparam logic [31:0] D_BASE = 32'hD000_00D0;

   axi_mem_port_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .LEN_WIDTH(8)) bus ();

   axi_mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .LEN_WIDTH(8)) dut (
      .ACLK    (ACLK),
      .ARESETn (ARESETn),
      .bus     (bus)
   );

   initial begin
      ACLK = 1'b0;
      forever #5 ACLK = ~ACLK;
   end

   logic [31:0] mem [1024];
   always @(posedge ACLK) begin
      if (bus.mem_en) begin
         if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
         else            bus.mem_rdata     <= mem[bus.mem_addr];
      end
   end

   // Reads issued but not yet popped.
   int occ = 0;
   int max_occ = 0;
   always @(posedge ACLK) begin
      if (!ARESETn) occ = 0;
      else begin
         occ = occ + int'(bus.mem_en && !bus.mem_we) - int'(bus.rd_data_valid && bus.rd_data_ready);
         if (occ > max_occ) max_occ = occ;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wr_burst(input logic [9:0] addr, input logic [7:0] len, input logic [31:0] base,
                           input bit with_rd, output logic rd_gnt_at_done);
      logic [9:0] a;
      @(negedge ACLK);
      bus.wr_req  = 1'b1;
      bus.wr_addr = addr;
      bus.wr_len  = len;
      if (with_rd) bus.rd_req = 1'b1;
      #1;
      check("wr_gnt", bus.wr_gnt, 1);
      check("rd_gnt_excl", bus.rd_gnt, 0);
      for (int i = 0; i <= int'(len); i++) begin
         @(negedge ACLK);
         bus.wr_req        = 1'b0;
         bus.wr_data_valid = 1'b1;
         bus.wr_data       = base + 32'(i);
         #1;
         a = addr + 10'(i);
         check("wr_ready", bus.wr_data_ready, 1);
         check("wr_mem_en_we", {bus.mem_en, bus.mem_we}, 2'b11);
         check("wr_mem_addr", bus.mem_addr, a);
         check("wr_mem_wdata", bus.mem_wdata, base + 32'(i));
         check("wr_done_early", bus.wr_done, 0);
         check("rd_gnt_in_wr", bus.rd_gnt, 0);
      end
      @(negedge ACLK);
      bus.wr_data_valid = 1'b0;
      #1;
      check("wr_done", bus.wr_done, 1);
      check("wr_ready_off", bus.wr_data_ready, 0);
      rd_gnt_at_done = bus.rd_gnt;
   endtask

   task automatic rd_burst(input logic [9:0] addr, input logic [7:0] len, input logic [31:0] base,
                           input logic [3:0] pat, input bit need_req);
      int k = 0;
      int first = -1;
      int last = -1;
      if (need_req) begin
         @(negedge ACLK);
         bus.rd_req  = 1'b1;
         bus.rd_addr = addr;
         bus.rd_len  = len;
         #1;
         check("rd_gnt", bus.rd_gnt, 1);
         check("wr_gnt_excl", bus.wr_gnt, 0);
      end
      for (int cyc = 0; cyc < 200 && k <= int'(len); cyc++) begin
         @(negedge ACLK);
         bus.rd_req        = 1'b0;
         bus.rd_data_ready = pat[cyc % 4];
         #1;
         if (bus.rd_data_valid && bus.rd_data_ready) begin
            check("rd_data", bus.rd_data, base + 32'(k));
            if (first < 0) first = cyc;
            last = cyc;
            k++;
         end
      end
      check("rd_beats", 64'(k), 64'(len) + 64'd1);
      @(negedge ACLK);
      bus.rd_data_ready = 1'b0;
      #1;
      check("rd_done", bus.rd_done, 1);
      check("rd_empty", bus.rd_data_valid, 0);
      if (pat == 4'hF) check("rd_consec", 64'(last - first), 64'(len));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   logic g;
   int   n;

   initial begin
      ARESETn           = 1'b0;
      bus.wr_req        = 1'b1;
      bus.wr_addr       = '0;
      bus.wr_len        = '0;
      bus.wr_data_valid = 1'b0;
      bus.wr_data       = '0;
      bus.rd_req        = 1'b1;
      bus.rd_addr       = '0;
      bus.rd_len        = '0;
      bus.rd_data_ready = 1'b0;
      bus.mem_rdata     = '0;

      repeat (2) @(negedge ACLK);
      #1;
      check("rst_wr_gnt", bus.wr_gnt, 0);
      check("rst_rd_gnt", bus.rd_gnt, 0);
      check("rst_mem_en", bus.mem_en, 0);
      check("rst_rd_valid", bus.rd_data_valid, 0);
      check("rst_wr_ready", bus.wr_data_ready, 0);
      check("rst_done", {bus.wr_done, bus.rd_done}, 2'b00);
      bus.wr_req = 1'b0;
      bus.rd_req = 1'b0;
      @(negedge ACLK);
      ARESETn = 1'b1;

      // basic write then read-back
      wr_burst(10'h010, 8'd3, A_BASE, 1'b0, g);
      for (int i = 0; i < 4; i++) check("mem_t1", mem[16 + i], A_BASE + 32'(i));
      rd_burst(10'h010, 8'd3, A_BASE, 4'hF, 1'b1);

      // simultaneous requests after reset: write wins, read granted on return to idle
      @(negedge ACLK);
      ARESETn = 1'b0;
      repeat (2) @(negedge ACLK);
      ARESETn     = 1'b1;
      bus.rd_addr = 10'h010;
      bus.rd_len  = 8'd3;
      wr_burst(10'h030, 8'd1, B_BASE, 1'b1, g);
      check("rd_gnt_at_wr_done", g, 1);
      rd_burst(10'h010, 8'd3, A_BASE, 4'hF, 1'b0);

      // address wrap
      wr_burst(10'h3FE, 8'd3, C_BASE, 1'b0, g);
      check("wrap_3fe", mem[1022], C_BASE);
      check("wrap_3ff", mem[1023], C_BASE + 32'd1);
      check("wrap_000", mem[0], C_BASE + 32'd2);
      check("wrap_001", mem[1], C_BASE + 32'd3);
      rd_burst(10'h3FE, 8'd3, C_BASE, 4'hF, 1'b1);

      // backpressure pattern 1,0,0,1
      wr_burst(10'h020, 8'd7, D_BASE, 1'b0, g);
      rd_burst(10'h020, 8'd7, D_BASE, 4'b1001, 1'b1);
      check("occ_le_2", max_occ <= 2, 1);

      // reset during beat 2 of a len=7 read
      @(negedge ACLK);
      bus.rd_req  = 1'b1;
      bus.rd_addr = 10'h020;
      bus.rd_len  = 8'd7;
      #1;
      check("t6_rd_gnt", bus.rd_gnt, 1);
      n = 0;
      do begin
         @(negedge ACLK);
         bus.rd_req        = 1'b0;
         bus.rd_data_ready = 1'b1;
         #1;
         n++;
      end while (!bus.rd_data_valid && n < 20);
      check("t6_first_beat", bus.rd_data, D_BASE);
      @(negedge ACLK);
      ARESETn = 1'b0;
      #1;
      check("t6_rst_valid", bus.rd_data_valid, 0);
      check("t6_rst_mem_en", bus.mem_en, 0);
      check("t6_rst_done", bus.rd_done, 0);
      repeat (2) begin
         @(negedge ACLK);
         #1;
         check("t6_hold_done", bus.rd_done, 0);
         check("t6_hold_valid", bus.rd_data_valid, 0);
      end
      @(negedge ACLK);
      ARESETn = 1'b1;
      #1;
      check("t6_post_valid", bus.rd_data_valid, 0);
      @(negedge ACLK);
      bus.rd_data_ready = 1'b0;
      #1;
      check("t6_post_done", bus.rd_done, 0);
      check("t6_post_mem_en", bus.mem_en, 0);
      rd_burst(10'h020, 8'd7, D_BASE, 4'hF, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
